mul_seq: RTL

Parametrised sequential shift-and-add multiplier producing a 2·WIDTH-bit product from two WIDTH-bit operands, one partial product per clock. It supports unsigned and two's-complement signed operands, selected per operation. It uses a start/busy/done handshake and is the area-lean successor to the combinational 4-bit array multiplier. It serves datapaths that can tolerate WIDTH+2 cycles of latency in exchange for a single adder.

---
 rtl/mul_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier: one partial product per clock, single adder.
// Signed operands are folded to magnitudes on accept and the sign is restored in FIX.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic [1:0]           dbg_state
);

  // Handshake: start is sampled on a rising edge only while busy=0; busy rises on
  // that accepting edge and falls on the result edge, where done pulses for one
  // cycle with out valid. start seen while busy=1 is dropped without effect.

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P    = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    acc_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    out_q;

  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic             neg_d;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    prod_d;

  always_comb begin
    mag_a_d = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
    mag_b_d = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;
    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    addend  = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    acc_d   = mplier_q[0] ? (acc_q + addend) : acc_q;
    prod_d  = neg_q ? (~acc_q + ONE_P) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_q <= FIX;
        end
        FIX: begin
          out_q   <= prod_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule
